fpu_result_select: RTL and testbench

Final stage of the FPU add/sub path. It sits directly downstream of the exception block and consumes its registered `exception_flag` and `copied_operand`. It holds each operation's exception record in a fixed-latency delay line until the normal add/sub datapath produces its result. It then emits one packed IEEE-754 result per operation: either the exception-derived value or the datapath value, plus status.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/exc_delay_line.sv | 42 ++++
 rtl/fpu_result_select.sv | 103 ++++++++++
 tb/tb_fpu_result_select.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag encoding, canonical NaN and the
// packed width of the exception record carried down the delay line.
package fpu_pkg;

   typedef logic [2:0] exc_flag_t;

   // Same encoding as the upstream exception block
   localparam exc_flag_t FLAG_NONE          = 3'b000;
   localparam exc_flag_t FLAG_NAN           = 3'b001;
   localparam exc_flag_t FLAG_COPY_A        = 3'b010;
   localparam exc_flag_t FLAG_COPY_B        = 3'b011;
   localparam exc_flag_t FLAG_FIN_MIN_INF   = 3'b100;
   localparam exc_flag_t FLAG_ZERO_MIN_ZERO = 3'b101;
   localparam exc_flag_t FLAG_ZERO_MIN_SOME = 3'b110;
   localparam exc_flag_t FLAG_SUB_SAME_VAL  = 3'b111;

   // Canonical single-precision quiet NaN
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Record = {flag, copied_operand, a_sign, b_sign, operation_select}
   function automatic int rec_width(input int width);
      return 3 + (width - 1) + 3;
   endfunction

endpackage

// File: rtl/exc_delay_line.sv
// Fixed-latency valid+payload shift register. No stall: every stage
// advances every cycle, so one record per cycle can enter back-to-back.
module exc_delay_line #(
   parameter int DEPTH  = 3,
   parameter int DATA_W = 37
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              tail_valid,
   output logic [DATA_W-1:0] tail_data
);

   logic              stage_valid [DEPTH];
   logic [DATA_W-1:0] stage_data  [DEPTH];

   // Shift records toward the tail; stage 0 loads a bubble when idle
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, which is what makes this a shift and not a copy.
      if (!arst_n) begin
         // NOTE: payloads are cleared on reset too, not just valid bits, so
         // no stale operand can ever be observed after reset.
         for (int i = 0; i < DEPTH; i++) begin
            stage_valid[i] <= 1'b0;
            stage_data[i]  <= '0;
         end
      end else begin
         stage_valid[0] <= in_valid;
         stage_data[0]  <= in_valid ? in_data : '0;
         for (int i = 1; i < DEPTH; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_data[i]  <= stage_data[i-1];
         end
      end
   end

   assign tail_valid = stage_valid[DEPTH-1];
   assign tail_data  = stage_data[DEPTH-1];

endmodule

// File: rtl/fpu_result_select.sv
// Final add/sub stage: delays the exception record until the datapath
// result arrives, then emits either the exception-derived value or the
// datapath value, plus status and a sticky misalignment indicator.
module fpu_result_select
   import fpu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int EXP_BITS   = 8,
   parameter int MANT_BITS  = 23,
   parameter int PIPE_DEPTH = 3
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             in_valid,
   input  logic [2:0]       exception_flag,
   input  logic [WIDTH-2:0] copied_operand,
   input  logic             a_sign,
   input  logic             b_sign,
   input  logic             operation_select,
   input  logic             norm_valid,
   input  logic [WIDTH-1:0] norm_result,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             from_exception,
   output logic             invalid_flag,
   output logic             sync_error
);

   localparam int REC_W = rec_width(WIDTH);

   logic             tail_valid;
   logic [REC_W-1:0] tail_data;
   exc_flag_t        tail_flag;
   logic [WIDTH-2:0] tail_copied;
   logic             tail_a_sign;
   logic             tail_b_sign;
   logic             tail_op_sub;

   logic [WIDTH-1:0] sel_result;
   logic             sel_from_exc;
   logic             sel_invalid;
   logic             zero_sign;

   exc_delay_line #(
      .DEPTH  (PIPE_DEPTH),
      .DATA_W (REC_W)
   ) u_delay (
      .clk        (clk),
      .arst_n     (arst_n),
      .in_valid   (in_valid),
      .in_data    ({exception_flag, copied_operand, a_sign, b_sign, operation_select}),
      .tail_valid (tail_valid),
      .tail_data  (tail_data)
   );

   assign {tail_flag, tail_copied, tail_a_sign, tail_b_sign, tail_op_sub} = tail_data;

   // Round-to-nearest sign of an exact zero result: -0 only if both terms are -0
   assign zero_sign = tail_op_sub ? (tail_a_sign & ~tail_b_sign)
                                  : (tail_a_sign &  tail_b_sign);

   // Map the tail record to the value it stands for
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch.
      sel_result   = norm_result;
      sel_from_exc = 1'b1;
      sel_invalid  = 1'b0;
      unique case (tail_flag)
         FLAG_NONE:          sel_from_exc = 1'b0;
         FLAG_NAN: begin
            sel_result  = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
            sel_invalid = 1'b1;
         end
         FLAG_COPY_A:        sel_result = {tail_a_sign, tail_copied};
         FLAG_COPY_B:        sel_result = {tail_b_sign, tail_copied};
         FLAG_FIN_MIN_INF:   sel_result = {~tail_b_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
         FLAG_ZERO_MIN_ZERO: sel_result = {zero_sign, {(WIDTH-1){1'b0}}};
         FLAG_ZERO_MIN_SOME: sel_result = {~tail_b_sign, tail_copied};
         FLAG_SUB_SAME_VAL:  sel_result = '0;
         default:            sel_result = norm_result;
      endcase
   end

   // Register the output record and accumulate alignment errors
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         out_valid      <= 1'b0;
         result         <= '0;
         from_exception <= 1'b0;
         invalid_flag   <= 1'b0;
         sync_error     <= 1'b0;
      end else begin
         out_valid      <= tail_valid;
         result         <= tail_valid ? sel_result : '0;
         from_exception <= tail_valid & sel_from_exc;
         invalid_flag   <= tail_valid & sel_invalid;
         if ((tail_valid && tail_flag == FLAG_NONE && !norm_valid) ||
             (norm_valid && !tail_valid))
            sync_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_result_select.sv
// Directed bench for fpu_result_select: a table of single operations with
// hand-computed results, plus hand-written multi-cycle corner sequences.
module tb_fpu_result_select;
   import fpu_pkg::*;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        in_valid;
   logic [2:0]  exception_flag;
   logic [30:0] copied_operand;
   logic        a_sign, b_sign, operation_select;
   logic        norm_valid;
   logic [31:0] norm_result;
   logic        out_valid;
   logic [31:0] result;
   logic        from_exception, invalid_flag, sync_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [2:0]  flag;
      logic [30:0] copied;
      logic        a_s, b_s, sub;
      logic [31:0] norm;
      logic [31:0] exp_result;
      logic        exp_fe, exp_inv;
   } vec_t;

   vec_t vecs [11];

   fpu_result_select #(
      .WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .PIPE_DEPTH(DEPTH)
   ) dut (
      .clk              (clk),
      .arst_n           (arst_n),
      .in_valid         (in_valid),
      .exception_flag   (exception_flag),
      .copied_operand   (copied_operand),
      .a_sign           (a_sign),
      .b_sign           (b_sign),
      .operation_select (operation_select),
      .norm_valid       (norm_valid),
      .norm_result      (norm_result),
      .out_valid        (out_valid),
      .result           (result),
      .from_exception   (from_exception),
      .invalid_flag     (invalid_flag),
      .sync_error       (sync_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid         = 1'b0;
      exception_flag   = 3'b000;
      copied_operand   = '0;
      a_sign           = 1'b0;
      b_sign           = 1'b0;
      operation_select = 1'b0;
      norm_valid       = 1'b0;
      norm_result      = '0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      arst_n = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " result"}, result, 32'd0);
      check({tag, " from_exc"}, {31'd0, from_exception}, 32'd0);
      check({tag, " invalid"}, {31'd0, invalid_flag}, 32'd0);
   endtask

   // One isolated operation; the datapath always fires DEPTH cycles later
   task automatic run_op(input vec_t v, input logic exp_sync);
      in_valid         = 1'b1;
      exception_flag   = v.flag;
      copied_operand   = v.copied;
      a_sign           = v.a_s;
      b_sign           = v.b_s;
      operation_select = v.sub;
      tick();
      idle_inputs();
      for (int i = 1; i < DEPTH; i++) tick();
      norm_valid  = 1'b1;
      norm_result = v.norm;
      tick();
      idle_inputs();
      check({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({v.name, " result"}, result, v.exp_result);
      check({v.name, " from_exc"}, {31'd0, from_exception}, {31'd0, v.exp_fe});
      check({v.name, " invalid"}, {31'd0, invalid_flag}, {31'd0, v.exp_inv});
      check({v.name, " sync"}, {31'd0, sync_error}, {31'd0, exp_sync});
      tick();
      check_idle_outputs({v.name, " after"});
   endtask

   logic [31:0] b2b_vals [3];

   initial begin
      vecs[0]  = '{"none",      FLAG_NONE,          31'h0,        0, 0, 0, 32'h3F80_0000, 32'h3F80_0000, 0, 0};
      vecs[1]  = '{"nan",       FLAG_NAN,           31'h1234_5678,1, 1, 0, 32'hDEAD_BEEF, QNAN,          1, 1};
      vecs[2]  = '{"copy_a",    FLAG_COPY_A,        31'h3FC0_0000,1, 0, 0, 32'h1234_5678, 32'hBFC0_0000, 1, 0};
      vecs[3]  = '{"copy_b",    FLAG_COPY_B,        31'h4049_0FDB,0, 1, 1, 32'hDEAD_BEEF, 32'hC049_0FDB, 1, 0};
      vecs[4]  = '{"inf_b1",    FLAG_FIN_MIN_INF,   31'h0,        0, 1, 0, 32'hDEAD_BEEF, 32'h7F80_0000, 1, 0};
      vecs[5]  = '{"inf_b0",    FLAG_FIN_MIN_INF,   31'h0,        0, 0, 1, 32'hDEAD_BEEF, 32'hFF80_0000, 1, 0};
      vecs[6]  = '{"zz_sub",    FLAG_ZERO_MIN_ZERO, 31'h0,        1, 0, 1, 32'hDEAD_BEEF, 32'h8000_0000, 1, 0};
      vecs[7]  = '{"zz_add",    FLAG_ZERO_MIN_ZERO, 31'h0,        1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0};
      vecs[8]  = '{"zz_add_nn", FLAG_ZERO_MIN_ZERO, 31'h0,        1, 1, 0, 32'hDEAD_BEEF, 32'h8000_0000, 1, 0};
      vecs[9]  = '{"zms",       FLAG_ZERO_MIN_SOME, 31'h40A0_0000,0, 0, 1, 32'hDEAD_BEEF, 32'hC0A0_0000, 1, 0};
      vecs[10] = '{"same_val",  FLAG_SUB_SAME_VAL,  31'h3F80_0000,1, 1, 1, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0};

      b2b_vals[0] = 32'h3F80_0000;
      b2b_vals[1] = 32'h4000_0000;
      b2b_vals[2] = 32'h4040_0000;

      // Reset state
      do_reset();
      check_idle_outputs("reset");
      check("reset sync", {31'd0, sync_error}, 32'd0);

      // Table of single operations
      foreach (vecs[i]) run_op(vecs[i], 1'b0);

      // Back-to-back NONE: issue at c=0..2, datapath at c=3..5, outputs at c=4..6
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         in_valid = (c < 3);
         if (c >= 3 && c <= 5) begin
            norm_valid  = 1'b1;
            norm_result = b2b_vals[c-3];
         end
         tick();
         if (c + 1 >= 4 && c + 1 <= 6) begin
            check("b2b out_valid", {31'd0, out_valid}, 32'd1);
            check("b2b result", result, b2b_vals[c+1-4]);
            check("b2b from_exc", {31'd0, from_exception}, 32'd0);
         end else begin
            check("b2b idle out_valid", {31'd0, out_valid}, 32'd0);
         end
         check("b2b sync", {31'd0, sync_error}, 32'd0);
      end
      idle_inputs();

      // Missing norm_valid: output still produced from the sampled bus, sync sticky
      in_valid = 1'b1;
      tick();
      idle_inputs();
      for (int i = 1; i < DEPTH; i++) tick();
      norm_result = 32'h55AA_55AA;
      tick();
      idle_inputs();
      check("miss out_valid", {31'd0, out_valid}, 32'd1);
      check("miss result", result, 32'h55AA_55AA);
      check("miss sync", {31'd0, sync_error}, 32'd1);
      tick();
      run_op(vecs[0], 1'b1);
      check("miss sync held", {31'd0, sync_error}, 32'd1);
      do_reset();
      check("miss sync cleared", {31'd0, sync_error}, 32'd0);

      // Spurious norm_valid with an empty pipe
      norm_valid  = 1'b1;
      norm_result = 32'h4000_0000;
      tick();
      idle_inputs();
      check("spur sync", {31'd0, sync_error}, 32'd1);
      check("spur out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("spur out_valid later", {31'd0, out_valid}, 32'd0);
      do_reset();

      // Reset mid-flight: ops at t and t+1, reset sampled at end of t+1
      in_valid = 1'b1;
      tick();
      arst_n = 1'b0;
      tick();
      arst_n   = 1'b1;
      in_valid = 1'b0;
      check_idle_outputs("rst_mid t+2");
      check("rst_mid sync t+2", {31'd0, sync_error}, 32'd0);
      tick();
      check_idle_outputs("rst_mid t+3");
      norm_valid  = 1'b1;
      norm_result = 32'h3F80_0000;
      tick();
      norm_result = 32'h4000_0000;
      check_idle_outputs("rst_mid t+4");
      check("rst_mid sync t+4", {31'd0, sync_error}, 32'd1);
      tick();
      idle_inputs();
      check_idle_outputs("rst_mid t+5");
      tick();
      check_idle_outputs("rst_mid t+6");
      check("rst_mid sync held", {31'd0, sync_error}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
